pwm_decoder: RTL and testbench
==============================

PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_W, default 16: width of period/high-time counters, in clk cycles.
REQ-002 clk  input  1  system clock, 100 MHz; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pwm_in  input  1  PWM signal to measure, asynchronous to clk.
REQ-005 period  output  CNT_W  clk cycles between the last two rising edges of pwm_in.
REQ-006 high_time  output  CNT_W  clk cycles pwm_in was high within that period.
REQ-007 duty_tenths  output  4  floor(high_time*10/period), range 0..10.
REQ-008 meas_valid  output  1  one-cycle pulse when period/high_time/duty_tenths update.
REQ-009 stuck  output  1  level; pwm_in has had no rising edge for 2^CNT_W-1 cycles.
REQ-010 overrun  output  1  sticky; a capture was dropped because the divider was busy.

Function
REQ-011 pwm_in SHALL pass a 2-FF synchronizer; rise = sync level high and previous sync level low.
REQ-012 FSM states SHALL be IDLE, MEASURE, STUCK; the divider runs independently of the FSM.
REQ-013 IDLE: on rise -> cnt=1, hcnt=1, go MEASURE; no outputs change.
REQ-014 MEASURE: each non-rise cycle cnt+=1, hcnt+=sync level; both saturate at 2^CNT_W-1.
REQ-015 MEASURE rise: capture (cnt, hcnt) to divider if idle, then reload cnt=1, hcnt=1, stay MEASURE.
REQ-016 If the divider is busy at capture: capture dropped, overrun set, counters still reload.
REQ-017 Divider: restoring long division of hcnt*10 (CNT_W+4 bits) by cnt, one quotient bit per cycle, bits 3..0, 4 busy cycles.
REQ-018 Latency: capture at cycle t; period, high_time, duty_tenths registered and meas_valid=1 at t+5; divider accepts a new capture at t+5.
REQ-019 Since hcnt<=cnt, quotient SHALL never exceed 10; no clamp logic is required.
REQ-020 MEASURE or IDLE with cnt reaching 2^CNT_W-1 without a rise: go STUCK, stuck=1, period=0, high_time=0, duty_tenths=10 if sync level high else 0, one meas_valid pulse.
REQ-021 STUCK: outputs held; on rise -> stuck=0, cnt=1, hcnt=1, go MEASURE; next meas_valid only after a full period.
REQ-022 In IDLE, cnt SHALL count cycles since reset for stuck detection only.
REQ-023 Outputs SHALL hold their last values between meas_valid pulses.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronizer, cnt, hcnt, divider and FSM (IDLE).
REQ-025 Reset values: period=0, high_time=0, duty_tenths=0, meas_valid=0, stuck=0, overrun=0.
REQ-026 A division in flight at reset SHALL be discarded without a meas_valid pulse.

Structure
REQ-027 Shared package pwm_pkg: DUTY_W=4, DUTY_FULL=10, FSM state enum, DIV_STEPS=4.
REQ-028 Divider SHALL be a sub-module pwm_div (start, dividend, divisor -> busy, done, quotient).
REQ-029 Target size 120-400 lines RTL total.

Verification
REQ-030 pwm_in period 10, high 5, repeating -> from second capture: period=10, high_time=5, duty_tenths=5, meas_valid once per 10 cycles, overrun=0.
REQ-031 pwm_in period 7, high 3 -> period=7, high_time=3, duty_tenths=4.
REQ-032 CNT_W=8, pwm_in held high after one rise -> stuck=1 at 255 cycles, duty_tenths=10, exactly one meas_valid; next rise clears stuck.
REQ-033 pwm_in period 4, high 2 -> overrun=1, reported values period=4, high_time=2, duty_tenths=5 on every other period.
REQ-034 rst_n low mid-division -> all outputs 0 immediately, no meas_valid; first report after reset requires two rises.
REQ-035 pwm_in period 10, high sweeping 0..10 across periods -> duty_tenths tracks 0..9 then stuck high with duty_tenths=10.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the PWM decoder and its divider.
//   DUTY_W     : width of the duty-cycle result (tenths, 0..10)
//   DUTY_FULL  : duty value reported for a 100 % (constantly high) input
//   DIV_STEPS  : quotient bits produced by the divider, one per cycle
//   pwm_state_e: measurement FSM states
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int DUTY_W    = 4;
    localparam int DUTY_FULL = 10;
    localparam int DIV_STEPS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_div.sv
// -----------------------------------------------------------------------------
// pwm_div
// Restoring divider producing a DUTY_W-bit quotient, one bit per cycle from
// the MSB down. The quotient is known to fit in DUTY_W bits, so only those
// bits are tried.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset, discards a division in flight
//   start    : load dividend/divisor; ignored while busy
//   dividend : numerator, CNT_W+DUTY_W bits
//   divisor  : denominator, CNT_W bits, must be non-zero
//   busy     : high for the DIV_STEPS cycles after start
//   done     : high in the last busy cycle, quotient valid alongside it
//   quotient : result, valid while done is high
// -----------------------------------------------------------------------------
module pwm_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W+DUTY_W-1:0]  dividend,
    input  logic [CNT_W-1:0]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic [DUTY_W-1:0]        quotient
);

    localparam int STEP_W = $clog2(DIV_STEPS);
    localparam int REM_W  = CNT_W + DUTY_W;

    logic [REM_W-1:0]  rem_q;
    logic [CNT_W-1:0]  divisor_q;
    logic [DUTY_W-1:0] quo_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;

    logic [REM_W-1:0]  shifted_d;
    logic              fits_d;
    logic [REM_W-1:0]  rem_d;
    logic [DUTY_W-1:0] quo_d;

    // Trial subtraction for the current quotient bit: compare the partial
    // remainder against the divisor weighted by that bit position. The final
    // step's quotient is exposed combinationally so the caller can register
    // it on the same edge the division finishes.
    always_comb begin
        shifted_d = {{DUTY_W{1'b0}}, divisor_q} << step_q;
        fits_d    = (rem_q >= shifted_d);
        rem_d     = fits_d ? (rem_q - shifted_d) : rem_q;
        quo_d     = quo_q;
        if (fits_d) begin
            quo_d = quo_q | (DUTY_W'(1) << step_q);
        end
    end

    // Operand load on start, then one quotient bit per cycle until the last
    // step clears busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_q - STEP_W'(1);
            if (step_q == '0) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            rem_q     <= dividend;
            divisor_q <= divisor;
            quo_q     <= '0;
            step_q    <= STEP_W'(DIV_STEPS - 1);
            busy_q    <= 1'b1;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == '0);
    assign quotient = quo_d;

endmodule

// File: rtl/pwm_decoder.sv
// -----------------------------------------------------------------------------
// pwm_decoder
// Measures period, high time and duty cycle (in tenths) of an asynchronous
// PWM input, and flags an input that has stopped toggling.
// Ports:
//   clk         : system clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset
//   pwm_in      : PWM signal to measure, asynchronous to clk
//   period      : clk cycles between the last two rising edges of pwm_in
//   high_time   : clk cycles pwm_in was high within that period
//   duty_tenths : floor(high_time*10/period)
//   meas_valid  : one-cycle pulse when the measurement outputs update
//   stuck       : pwm_in has had no rising edge for 2^CNT_W-1 cycles
//   overrun     : sticky, a capture was dropped because the divider was busy
// -----------------------------------------------------------------------------
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [3:0]        duty_tenths,
    output logic              meas_valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(DUTY_FULL);

    // Synchronizer and edge detect
    logic sync1_q;
    logic sync2_q;
    logic syncPrev_q;
    logic rise;
    logic syncLevel;

    // Measurement FSM state and counters
    pwm_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  hcnt_q;
    logic [CNT_W-1:0]  capPeriod_q;
    logic [CNT_W-1:0]  capHigh_q;

    // Registered outputs
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  highTime_q;
    logic [DUTY_W-1:0] duty_q;
    logic              measValid_q;
    logic              stuck_q;
    logic              overrun_q;

    // Next-count values and divider interface
    logic [CNT_W-1:0]        cntInc_d;
    logic [CNT_W-1:0]        hcntInc_d;
    logic                    reachMax_d;
    logic                    divStart;
    logic                    divBusy;
    logic                    divDone;
    logic [DUTY_W-1:0]       divQuotient;
    logic [CNT_W+DUTY_W-1:0] dividend;

    // Two-flop synchronizer on pwm_in plus one more flop to remember the
    // previous synchronized level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            syncPrev_q <= 1'b0;
        end else begin
            sync1_q    <= pwm_in;
            sync2_q    <= sync1_q;
            syncPrev_q <= sync2_q;
        end
    end

    assign syncLevel = sync2_q;
    assign rise      = sync2_q && !syncPrev_q;

    // Saturating counter increments. reachMax_d marks the cycle in which the
    // period counter would hit its ceiling, which is when the input is
    // declared stuck.
    always_comb begin
        cntInc_d  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        hcntInc_d = (hcnt_q == CNT_MAX) ? hcnt_q : (hcnt_q + CNT_W'(syncLevel));
        reachMax_d = (cntInc_d == CNT_MAX);
    end

    // hcnt*10 computed as hcnt*8 + hcnt*2; the extra DUTY_W bits hold the
    // full product without overflow.
    assign dividend = ({{DUTY_W{1'b0}}, hcnt_q} << 3) + ({{DUTY_W{1'b0}}, hcnt_q} << 1);
    assign divStart = (state_q == MEASURE) && rise && !divBusy;

    pwm_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (divStart),
        .dividend (dividend),
        .divisor  (cnt_q),
        .busy     (divBusy),
        .done     (divDone),
        .quotient (divQuotient)
    );

    // Measurement FSM with registered outputs. Divider results land on the
    // outputs when it finishes; entering STUCK is written after that so it
    // takes precedence should both ever coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            capPeriod_q <= '0;
            capHigh_q   <= '0;
            period_q    <= '0;
            highTime_q  <= '0;
            duty_q      <= '0;
            measValid_q <= 1'b0;
            stuck_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            measValid_q <= 1'b0;

            if (divDone) begin
                period_q    <= capPeriod_q;
                highTime_q  <= capHigh_q;
                duty_q      <= divQuotient;
                measValid_q <= 1'b1;
            end

            if (divStart) begin
                capPeriod_q <= cnt_q;
                capHigh_q   <= hcnt_q;
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_q   <= CNT_ONE;
                        hcnt_q  <= CNT_ONE;
                        state_q <= MEASURE;
                    end else begin
                        cnt_q <= cntInc_d;
                        if (reachMax_d) begin
                            state_q     <= STUCK;
                            stuck_q     <= 1'b1;
                            period_q    <= '0;
                            highTime_q  <= '0;
                            duty_q      <= syncLevel ? DUTY_TOP : '0;
                            measValid_q <= 1'b1;
                        end
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        cnt_q  <= CNT_ONE;
                        hcnt_q <= CNT_ONE;
                        if (divBusy) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cntInc_d;
                        hcnt_q <= hcntInc_d;
                        if (reachMax_d) begin
                            state_q     <= STUCK;
                            stuck_q     <= 1'b1;
                            period_q    <= '0;
                            highTime_q  <= '0;
                            duty_q      <= syncLevel ? DUTY_TOP : '0;
                            measValid_q <= 1'b1;
                        end
                    end
                end

                STUCK: begin
                    if (rise) begin
                        stuck_q <= 1'b0;
                        cnt_q   <= CNT_ONE;
                        hcnt_q  <= CNT_ONE;
                        state_q <= MEASURE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign period      = period_q;
    assign high_time   = highTime_q;
    assign duty_tenths = duty_q;
    assign meas_valid  = measValid_q;
    assign stuck       = stuck_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_decoder
// Directed bench for pwm_decoder with CNT_W=8 so the stuck timeout is short.
// -----------------------------------------------------------------------------
module tb_pwm_decoder;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwmIn;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] highTime;
    logic [3:0]       dutyTenths;
    logic             measValid;
    logic             stuck;
    logic             overrun;

    int checks     = 0;
    int failures   = 0;
    int pulseCount = 0;
    int base;

    pwm_decoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwmIn),
        .period      (period),
        .high_time   (highTime),
        .duty_tenths (dutyTenths),
        .meas_valid  (measValid),
        .stuck       (stuck),
        .overrun     (overrun)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count measurement pulses, sampled on the falling edge away from updates
    always @(negedge clk) begin
        if (rst_n && measValid) begin
            pulseCount++;
        end
    end

    // Safety net so the bench never hangs
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a number of PWM periods with the given high and low durations
    task automatic applyStimulus(input int highCycles, input int lowCycles, input int periods);
        for (int p = 0; p < periods; p++) begin
            pwmIn = 1'b1;
            waitCycles(highCycles);
            if (lowCycles > 0) begin
                pwmIn = 1'b0;
                waitCycles(lowCycles);
            end
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        pwmIn = 1'b0;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(2);
    endtask

    initial begin
        rst_n = 1'b0;
        pwmIn = 1'b0;
        waitCycles(3);
        checkOutput("rst_period",   int'(period),     0);
        checkOutput("rst_high",     int'(highTime),   0);
        checkOutput("rst_duty",     int'(dutyTenths), 0);
        checkOutput("rst_valid",    int'(measValid),  0);
        checkOutput("rst_stuck",    int'(stuck),      0);
        checkOutput("rst_overrun",  int'(overrun),    0);
        rst_n = 1'b1;
        waitCycles(2);

        // Period 10, high 5: one report every 10 cycles
        applyStimulus(5, 5, 12);
        base = pulseCount;
        applyStimulus(5, 5, 10);
        checkOutput("p10_pulses",  pulseCount - base, 10);
        checkOutput("p10_period",  int'(period),      10);
        checkOutput("p10_high",    int'(highTime),    5);
        checkOutput("p10_duty",    int'(dutyTenths),  5);
        checkOutput("p10_overrun", int'(overrun),     0);
        checkOutput("p10_stuck",   int'(stuck),       0);

        // Period 7, high 3: 30/7 floors to 4
        applyStimulus(3, 4, 6);
        checkOutput("p7_period", int'(period),     7);
        checkOutput("p7_high",   int'(highTime),   3);
        checkOutput("p7_duty",   int'(dutyTenths), 4);

        // Duty sweep at period 10
        for (int h = 1; h <= 9; h++) begin
            applyStimulus(h, 10 - h, 3);
            checkOutput($sformatf("sweep_duty_h%0d", h),   int'(dutyTenths), h);
            checkOutput($sformatf("sweep_high_h%0d", h),   int'(highTime),   h);
            checkOutput($sformatf("sweep_period_h%0d", h), int'(period),     10);
        end
        checkOutput("sweep_overrun", int'(overrun), 0);

        // Hold high: the last period is reported, then stuck after 255 cycles
        applyStimulus(5, 5, 3);
        pwmIn = 1'b1;
        waitCycles(20);
        base = pulseCount;
        waitCycles(220);
        checkOutput("stuck_early", int'(stuck), 0);
        waitCycles(30);
        checkOutput("stuck_set",    int'(stuck),      1);
        checkOutput("stuck_duty",   int'(dutyTenths), 10);
        checkOutput("stuck_period", int'(period),     0);
        checkOutput("stuck_high",   int'(highTime),   0);
        checkOutput("stuck_pulses", pulseCount - base, 1);

        // Low phase keeps stuck; next rise clears it with no immediate report
        pwmIn = 1'b0;
        waitCycles(5);
        checkOutput("stuck_hold_low", int'(stuck), 1);
        base = pulseCount;
        pwmIn = 1'b1;
        waitCycles(5);
        checkOutput("stuck_cleared", int'(stuck), 0);
        pwmIn = 1'b0;
        waitCycles(5);
        checkOutput("unstuck_no_pulse",  pulseCount - base, 0);
        checkOutput("unstuck_held_duty", int'(dutyTenths),  10);
        applyStimulus(5, 5, 3);
        checkOutput("unstuck_period", int'(period),     10);
        checkOutput("unstuck_duty",   int'(dutyTenths), 5);

        // Period 4 outruns the divider: every other period reported
        applyReset();
        checkOutput("ovr_before", int'(overrun), 0);
        applyStimulus(2, 2, 12);
        base = pulseCount;
        applyStimulus(2, 2, 20);
        checkOutput("ovr_pulses",  pulseCount - base, 10);
        checkOutput("ovr_flag",    int'(overrun),     1);
        checkOutput("ovr_period",  int'(period),      4);
        checkOutput("ovr_high",    int'(highTime),    2);
        checkOutput("ovr_duty",    int'(dutyTenths),  5);

        // Reset while a division is in flight
        applyStimulus(5, 5, 3);
        pwmIn = 1'b1;
        waitCycles(4);
        #2;
        rst_n = 1'b0;
        pwmIn = 1'b0;
        #1;
        checkOutput("mid_rst_period",  int'(period),     0);
        checkOutput("mid_rst_high",    int'(highTime),   0);
        checkOutput("mid_rst_duty",    int'(dutyTenths), 0);
        checkOutput("mid_rst_valid",   int'(measValid),  0);
        checkOutput("mid_rst_overrun", int'(overrun),    0);
        base = pulseCount;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(10);
        checkOutput("mid_rst_no_pulse", pulseCount - base, 0);
        applyStimulus(5, 5, 1);
        checkOutput("after_rst_one_rise", pulseCount - base, 0);
        applyStimulus(5, 5, 1);
        checkOutput("after_rst_two_rise", pulseCount - base, 1);
        checkOutput("after_rst_period",   int'(period),     10);
        checkOutput("after_rst_duty",     int'(dutyTenths), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
